norm_iter: RTL and testbench
============================

NORM_ITER -- requirements
Module: norm_iter

Interface
REQ-001 Parameter EXP, default 8, exponent width in bits (two's-complement signed).
REQ-002 Parameter MAN, default 23, stored mantissa width; the MSB is explicit, with no hidden bit.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block can accept an input.
REQ-007 s_in  input  1  sign of the raw sum.
REQ-008 e_in  input  EXP  signed exponent of the raw sum.
REQ-009 m_in  input  MAN+1  unnormalized magnitude; bit MAN is the carry from addition.
REQ-010 out_valid  output  1  result held stable.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out  output  MAN+EXP+1  packed word {sign, exponent[EXP-1:0], mantissa[MAN-1:0]}.
REQ-013 out_zero, out_uflow, out_oflow  output  1 each  status flags, valid while out_valid is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE. Encodings SHALL be in the package.
REQ-015 in_ready SHALL be high only in IDLE; acceptance = in_valid & in_ready at a rising edge. Acceptance SHALL move the FSM to SHIFT.
REQ-016 On acceptance, if m_in[MAN]=1:
- m_reg SHALL load m_in>>1 (low MAN bits) and e_reg SHALL load e_in+1.
- If e_in=EMAX (2^(EXP-1)-1), the result SHALL saturate instead: e_reg=EMAX, m_reg=all ones, oflow set.
- Otherwise m_reg SHALL load m_in[MAN-1:0] and e_reg SHALL load e_in.
REQ-017 In SHIFT, the FSM SHALL go to DONE on the first of these conditions, checked in order:
- m_reg=0: set zero, force e_reg=EMIN (-2^(EXP-1)), force sign to 0.
- m_reg[MAN-1]=1: normalized.
- e_reg=EMIN: set uflow and leave the mantissa unnormalized.
REQ-018 Otherwise, in SHIFT, m_reg SHALL shift left by one bit (zero fill) and e_reg SHALL decrement by one, exactly one shift per cycle.
REQ-019 Latency from the acceptance edge to out_valid high SHALL be 2+N cycles, where N is the number of left shifts. Maximum N = MAN-1.
REQ-020 In DONE, out_valid SHALL be high, and out and the flags SHALL be held constant until out_ready is sampled high.
REQ-021 When out_ready is sampled high in DONE, the FSM SHALL go to IDLE. A new input SHALL NOT be accepted before the following cycle, so minimum issue interval = 3 cycles.
REQ-022 out_ready SHALL be ignored outside DONE. in_valid SHALL be ignored outside IDLE.
REQ-023 Input fields SHALL be captured only at acceptance; later input changes SHALL have no effect.
REQ-024 Exponent arithmetic SHALL be EXP-bit signed and SHALL never wrap; the saturation rules in REQ-016 and REQ-017 apply at both limits.
REQ-025 Flags SHALL be mutually exclusive and SHALL be cleared at acceptance.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE regardless of the current state, discarding any operation in flight without emitting a result.
REQ-027 Reset values SHALL be: in_ready=1 (from the first cycle after reset), out_valid=0, out=0, and all flags 0.

Structure
REQ-028 A shared package norm_pkg SHALL hold:
- default EXP and MAN;
- the EMIN and EMAX functions of EXP;
- the state enum.
REQ-029 The block SHALL be a single module with no sub-module. The shift/decrement datapath and the FSM together are about 150-250 lines.

Verification
REQ-030 With EXP=8, MAN=23:
- Stimulus: s=0, e=8'h05, m_in=24'h400000.
- Response: out={0,8'h05,23'h400000} with out_valid high 2 cycles after acceptance, no flags.
REQ-031 Carry case:
- Stimulus: s=1, e=8'h03, m_in=24'h800000.
- Response: out={1,8'h04,23'h400000}, 2 cycles.
- Also: e=8'h7F, m_in=24'h800000 gives e=8'h7F, m=23'h7FFFFF, out_oflow=1.
REQ-032 Maximum shift:
- Stimulus: e=8'd30, m_in=24'h000001.
- Response: 22 shifts, out={0,8'd8,23'h400000}, out_valid 24 cycles after acceptance.
REQ-033 Zero and underflow:
- Stimulus: m_in=0, s=1. Response: out={0,8'h80,23'h0}, out_zero=1.
- Stimulus: e=8'h81, m_in=24'h000100. Response: one shift, then e=8'h80, m=23'h000200, out_uflow=1.
REQ-034 Handshake: hold out_ready low 5 cycles in DONE, then confirm:
- out and flags stay stable;
- in_ready stays low until the cycle after out_ready is sampled high.
REQ-035 Reset mid-operation:
- Stimulus: assert rst for 1 cycle in the middle of a 10-shift SHIFT operation.
- Response: next cycle IDLE, in_ready=1, out_valid=0; a new input completes correctly.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared widths, exponent limits and FSM encoding for the iterative normalizer.
package norm_pkg;

    localparam int EXP_DEF = 8;
    localparam int MAN_DEF = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int emin_f(input int exp_w);
        return -(1 << (exp_w - 1));
    endfunction

    function automatic int emax_f(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/norm_iter.sv
// Iterative float normalizer: one left shift per cycle, result out_valid 2+N edges after acceptance.
// Result is held in DONE until out_ready; in_ready only in IDLE.
module norm_iter
    import norm_pkg::*;
#(
    parameter int EXP = EXP_DEF,
    parameter int MAN = MAN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               s_in,
    input  logic [EXP-1:0]     e_in,
    input  logic [MAN:0]       m_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN+EXP:0]   out,
    output logic               out_zero,
    output logic               out_uflow,
    output logic               out_oflow
);

    localparam logic [EXP-1:0] EMIN = EXP'(emin_f(EXP));
    localparam logic [EXP-1:0] EMAX = EXP'(emax_f(EXP));

    state_e           state_q, state_d;
    logic             s_q, s_d;
    logic [EXP-1:0]   e_q, e_d;
    logic [MAN-1:0]   m_q, m_d;
    logic             zero_q, zero_d;
    logic             uflow_q, uflow_d;
    logic             oflow_q, oflow_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        zero_d  = zero_q;
        uflow_d = uflow_q;
        oflow_d = oflow_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    s_d     = s_in;
                    zero_d  = 1'b0;
                    uflow_d = 1'b0;
                    oflow_d = 1'b0;
                    if (m_in[MAN]) begin
                        // Carry out of the adder: renormalize right, saturating at EMAX.
                        if (e_in == EMAX) begin
                            e_d     = EMAX;
                            m_d     = '1;
                            oflow_d = 1'b1;
                        end else begin
                            e_d = e_in + EXP'(1);
                            m_d = m_in[MAN:1];
                        end
                    end else begin
                        e_d = e_in;
                        m_d = m_in[MAN-1:0];
                    end
                end
            end
            SHIFT: begin
                if (m_q == '0) begin
                    state_d = DONE;
                    zero_d  = 1'b1;
                    e_d     = EMIN;
                    s_d     = 1'b0;
                end else if (m_q[MAN-1]) begin
                    state_d = DONE;
                end else if (e_q == EMIN) begin
                    // Exponent floor reached: leave the mantissa denormal.
                    state_d = DONE;
                    uflow_d = 1'b1;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - EXP'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= '0;
            m_q     <= '0;
            zero_q  <= 1'b0;
            uflow_q <= 1'b0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            zero_q  <= zero_d;
            uflow_q <= uflow_d;
            oflow_q <= oflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = {s_q, e_q, m_q};
    assign out_zero  = zero_q;
    assign out_uflow = uflow_q;
    assign out_oflow = oflow_q;

endmodule

// File: tb/tb_norm_iter.sv
// Directed and randomized checks of norm_iter against an arithmetic reference model.
module tb_norm_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        s_in;
    logic [7:0]  e_in;
    logic [23:0] m_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_zero;
    logic        out_uflow;
    logic        out_oflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  flags;   // {zero, uflow, oflow}
        logic [7:0]  lat;
    } exp_t;

    norm_iter #(.EXP(8), .MAN(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .e_in      (e_in),
        .m_in      (m_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_zero  (out_zero),
        .out_uflow (out_uflow),
        .out_oflow (out_oflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: integer exponent/mantissa arithmetic, shift count from the leading-one position.
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [23:0] m);
        exp_t        r;
        int          ev, mv, msb, need, avail, n;
        logic        sg;
        logic [31:0] evb, mvb;
        ev = int'($signed(e));
        mv = int'(m);
        sg = s;
        r.flags = 3'b000;
        n = 0;
        if (mv >= (1 << 23)) begin
            if (ev == 127) begin
                mv = (1 << 23) - 1;
                r.flags = 3'b001;
            end else begin
                mv = mv / 2;
                ev = ev + 1;
            end
        end
        if (mv == 0) begin
            r.flags = 3'b100;
            sg = 1'b0;
            ev = -128;
        end else begin
            msb = 0;
            for (int i = 0; i < 23; i++) if (mv >= (1 << i)) msb = i;
            need  = 22 - msb;
            avail = ev + 128;
            n = (need < avail) ? need : avail;
            if (avail < need) r.flags = 3'b010;
            mv = mv * (1 << n);
            ev = ev - n;
        end
        evb = ev;
        mvb = mv;
        r.word = {sg, evb[7:0], mvb[22:0]};
        r.lat  = 8'(n + 2);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [23:0] m,
                          input logic [31:0] ew, input logic [2:0] ef, input int elat, input int hold);
        int k;
        check({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        s_in = s;
        e_in = e;
        m_in = m;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        s_in = $urandom();
        e_in = $urandom();
        m_in = $urandom();
        check({tag, ".in_ready_busy"}, in_ready, 0);
        k = 0;
        while (out_valid !== 1'b1 && k <= 60) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = $urandom_range(0, 1);
            k++;
        end
        in_valid = 1'b0;
        if (k > 60) begin
            checks++;
            failures++;
            $error("FAIL %s.timeout observed=no_out_valid expected=out_valid", tag);
            return;
        end
        check({tag, ".latency"}, k + 1, elat);
        check({tag, ".out"}, out, ew);
        check({tag, ".flags"}, {out_zero, out_uflow, out_oflow}, ef);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_out"}, {out_valid, in_ready, out}, {1'b1, 1'b0, ew});
            check({tag, ".hold_flags"}, {out_zero, out_uflow, out_oflow}, ef);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        exp_t  r;
        logic  s;
        logic [7:0]  e;
        logic [23:0] m;
        bit    seen_valid;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s_in = 1'b0;
        e_in = '0;
        m_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.ready_valid", {in_ready, out_valid}, 2'b10);
        check("reset.out", out, 0);
        check("reset.flags", {out_zero, out_uflow, out_oflow}, 3'b000);

        run_op("norm_hold", 1'b0, 8'h05, 24'h400000, {1'b0, 8'h05, 23'h400000}, 3'b000, 2, 5);
        run_op("carry", 1'b1, 8'h03, 24'h800000, {1'b1, 8'h04, 23'h400000}, 3'b000, 2, 0);
        run_op("oflow", 1'b0, 8'h7F, 24'h800000, {1'b0, 8'h7F, 23'h7FFFFF}, 3'b001, 2, 1);
        run_op("max_shift", 1'b0, 8'd30, 24'h000001, {1'b0, 8'd8, 23'h400000}, 3'b000, 24, 0);
        run_op("zero", 1'b1, 8'h10, 24'h000000, {1'b0, 8'h80, 23'h000000}, 3'b100, 2, 2);
        run_op("uflow", 1'b0, 8'h81, 24'h000100, {1'b0, 8'h80, 23'h000200}, 3'b010, 3, 0);
        run_op("carry_emin", 1'b1, 8'h80, 24'hFFFFFF, {1'b1, 8'h81, 23'h7FFFFF}, 3'b000, 2, 0);

        // Reset in the middle of a 10-shift operation.
        in_valid = 1'b1;
        s_in = 1'b1;
        e_in = 8'd40;
        m_in = 24'h001000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst.ready_valid", {in_ready, out_valid}, 2'b10);
        check("midrst.out", out, 0);
        seen_valid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("midrst.no_result", seen_valid, 0);
        run_op("after_rst", 1'b0, 8'd40, 24'h001000, {1'b0, 8'd30, 23'h400000}, 3'b000, 12, 0);

        for (int i = 0; i < 30; i++) begin
            s = 1'(($urandom() & 32'h1));
            e = 8'($urandom());
            m = 24'(($urandom() & 32'hFFFFFF) >> $urandom_range(0, 24));
            if (i % 7 == 0) e = (i % 2 == 0) ? 8'h7F : 8'h80 + 8'($urandom_range(0, 5));
            r = model(s, e, m);
            run_op("random", s, e, m, r.word, r.flags, int'(r.lat), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
